// File: rtl/matrix_3x3_gen_pkg.sv
// Shared constants and types for the 3x3 window generator.
package matrix_3x3_gen_pkg;
  localparam int DATA_W  = 8;
  localparam int LATENCY = 2;

  typedef struct packed {
    logic [DATA_W-1:0] top;  // row y-2
    logic [DATA_W-1:0] mid;  // row y-1
    logic [DATA_W-1:0] bot;  // row y
  } col_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/matrix_3x3_gen_line_buf_ram.sv
// Simple dual-port line buffer with one-cycle registered read; contents are not reset.
module line_buf_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 16,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end
endmodule

// File: rtl/matrix_3x3_gen.sv
// 3x3 sliding window over a raster pixel stream; two line buffers packed in one RAM word,
// two column shift registers, sync signals delayed to stay aligned with the window.
module matrix_3x3_gen
  import matrix_3x3_gen_pkg::*;
#(
  parameter int IMG_WIDTH = 640
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_y,
  output logic              matrix_frame_vsync,
  output logic              matrix_frame_href,
  output logic              matrix_frame_clken,
  output logic [DATA_W-1:0] data11, data12, data13,
  output logic [DATA_W-1:0] data21, data22, data23,
  output logic [DATA_W-1:0] data31, data32, data33
);
  localparam int            AW   = addr_w(IMG_WIDTH);
  localparam logic [AW-1:0] XMAX = AW'(IMG_WIDTH - 1);

  logic               r_vs_d, r_hs_d, r_frame_ok, r_x_ovf;
  logic [AW-1:0]      r_x_cnt;
  logic [1:0]         r_y_cnt;
  logic [LATENCY-1:0] r_vs_pipe, r_hs_pipe, r_ck_pipe;
  logic               r_s1_vld, r_s1_inr;
  logic [DATA_W-1:0]  r_s1_pix;
  logic [AW-1:0]      r_s1_x;
  logic [1:0]         r_s1_y;
  col_t               r_c2, r_c3, r_w1, r_w2, r_w3, w_new;
  logic [2*DATA_W-1:0] w_rd_data;
  logic               w_vs_rise, w_hs_fall, w_acc;

  assign w_vs_rise = per_frame_vsync & ~r_vs_d;
  assign w_hs_fall = ~per_frame_href & r_hs_d;
  assign w_acc     = r_frame_ok & per_frame_href & per_frame_clken;

  // Out-of-range columns beyond IMG_WIDTH have no buffered history: drop rows 1/2.
  function automatic col_t row_mask(input col_t c, input logic inr);
    col_t m;
    m = c;
    if (!inr) begin
      m.top = '0;
      m.mid = '0;
    end
    return m;
  endfunction

  always_comb begin
    w_new     = '0;
    w_new.top = (r_s1_inr && r_s1_y == 2'd2) ? w_rd_data[2*DATA_W-1:DATA_W] : '0;
    w_new.mid = (r_s1_inr && r_s1_y != 2'd0) ? w_rd_data[DATA_W-1:0]        : '0;
    w_new.bot = r_s1_pix;
  end

  line_buf_ram #(.DEPTH(IMG_WIDTH), .WIDTH(2*DATA_W), .AW(AW)) u_ram (
    .clk       (clk),
    .i_wr_en   (r_s1_vld & r_s1_inr),
    .i_wr_addr (r_s1_x),
    .i_wr_data ({w_rd_data[DATA_W-1:0], r_s1_pix}),
    .i_rd_en   (w_acc & ~r_x_ovf),
    .i_rd_addr (r_x_cnt),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_d     <= 1'b0;
      r_hs_d     <= 1'b0;
      r_frame_ok <= 1'b0;
      r_x_cnt    <= '0;
      r_x_ovf    <= 1'b0;
      r_y_cnt    <= '0;
      r_vs_pipe  <= '0;
      r_hs_pipe  <= '0;
      r_ck_pipe  <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_inr   <= 1'b0;
      r_s1_pix   <= '0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_c2       <= '0;
      r_c3       <= '0;
      r_w1       <= '0;
      r_w2       <= '0;
      r_w3       <= '0;
    end else begin
      r_vs_d     <= per_frame_vsync;
      r_hs_d     <= per_frame_href;
      r_frame_ok <= r_frame_ok | w_vs_rise;
      r_vs_pipe  <= {r_vs_pipe[LATENCY-2:0], per_frame_vsync};
      r_hs_pipe  <= {r_hs_pipe[LATENCY-2:0], per_frame_href};
      r_ck_pipe  <= {r_ck_pipe[LATENCY-2:0], per_frame_clken & r_frame_ok};

      // vsync clear takes priority over a coincident href fall
      if (w_vs_rise) begin
        r_x_cnt <= '0;
        r_x_ovf <= 1'b0;
        r_y_cnt <= '0;
      end else if (w_hs_fall) begin
        r_x_cnt <= '0;
        r_x_ovf <= 1'b0;
        if (r_y_cnt != 2'd2) r_y_cnt <= r_y_cnt + 2'd1;
      end else if (w_acc) begin
        if (r_x_cnt == XMAX) r_x_ovf <= 1'b1;
        else                 r_x_cnt <= r_x_cnt + 1'b1;
      end

      r_s1_vld <= w_acc;
      if (w_acc) begin
        r_s1_pix <= per_img_y;
        r_s1_x   <= r_x_cnt;
        r_s1_inr <= ~r_x_ovf;
        r_s1_y   <= r_y_cnt;
      end

      if (r_s1_vld) begin
        r_c2 <= r_c3;
        r_c3 <= w_new;
        r_w3 <= w_new;
        r_w2 <= (r_s1_x != '0)      ? row_mask(r_c3, r_s1_inr) : '0;
        r_w1 <= (r_s1_x >= AW'(2))  ? row_mask(r_c2, r_s1_inr) : '0;
      end
    end
  end

  assign matrix_frame_vsync = r_vs_pipe[LATENCY-1];
  assign matrix_frame_href  = r_hs_pipe[LATENCY-1];
  assign matrix_frame_clken = r_ck_pipe[LATENCY-1];
  assign {data11, data21, data31} = {r_w1.top, r_w1.mid, r_w1.bot};
  assign {data12, data22, data32} = {r_w2.top, r_w2.mid, r_w2.bot};
  assign {data13, data23, data33} = {r_w3.top, r_w3.mid, r_w3.bot};
endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Directed bench for matrix_3x3_gen at IMG_WIDTH=4 with an image-level reference model.
module tb_matrix_3x3_gen;
  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst, vs, hs, ck;
  logic [7:0] pix;
  logic       o_vs, o_hs, o_ck;
  logic [7:0] d11, d12, d13, d21, d22, d23, d31, d32, d33;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  matrix_3x3_gen #(.IMG_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vs), .per_frame_href(hs), .per_frame_clken(ck), .per_img_y(pix),
    .matrix_frame_vsync(o_vs), .matrix_frame_href(o_hs), .matrix_frame_clken(o_ck),
    .data11(d11), .data12(d12), .data13(d13),
    .data21(d21), .data22(d22), .data23(d23),
    .data31(d31), .data32(d32), .data33(d33)
  );

  wire [71:0] dut_win = {d11, d12, d13, d21, d22, d23, d31, d32, d33};

  logic [7:0]  img [16][16];
  logic [71:0] cap [$];

  // reference state
  logic        e_vs = 0, e_hs = 0, e_ck = 0, p_vs = 0, p_hs = 0, p_ck = 0;
  logic        fok = 0, vs_prev = 0, hs_prev = 0, pend_v = 0;
  logic [71:0] e_win = '0, pend = '0;
  int          line = 0, col = 0;

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Window straight from the image: row r=line-2+dr, column c=col-2+dc, zero outside.
  function automatic logic [71:0] mk_win(input int ln, input int cl);
    logic [71:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        int r, c;
        r = ln - 2 + dr;
        c = cl - 2 + dc;
        if (r >= 0 && c >= 0 && r < 16 && c < 16 && !(dr < 2 && cl >= W))
          w[8*(8-(3*dr+dc)) +: 8] = img[r][c];
      end
    return w;
  endfunction

  initial begin
    forever begin
      logic acc, vsr, hsf;
      @(negedge clk);
      check("vsync_out", o_vs, e_vs);
      check("href_out",  o_hs, e_hs);
      check("clken_out", o_ck, e_ck);
      check("window",    dut_win, e_win);
      if (o_ck) cap.push_back(dut_win);
      // advance model through the coming rising edge
      if (rst) begin
        {e_vs, e_hs, e_ck, p_vs, p_hs, p_ck} = '0;
        {fok, vs_prev, hs_prev, pend_v} = '0;
        e_win = '0;
        line = 0;
        col = 0;
      end else begin
        {e_vs, e_hs, e_ck} = {p_vs, p_hs, p_ck};
        {p_vs, p_hs, p_ck} = {vs, hs, ck & fok};
        if (pend_v) e_win = pend;
        pend_v = 0;
        acc = fok & hs & ck;
        if (acc && line < 16 && col < 16) begin
          img[line][col] = pix;
          pend = mk_win(line, col);
          pend_v = 1;
        end
        vsr = vs & ~vs_prev;
        hsf = ~hs & hs_prev;
        if (vsr) begin
          line = 0;
          col = 0;
          for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) img[r][c] = '0;
          fok = 1;
        end else if (hsf) begin
          line++;
          col = 0;
        end else if (acc) col++;
        vs_prev = vs;
        hs_prev = hs;
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic px(input int y, input int x);
    hs = 1; ck = 1; pix = 8'(16*y + x + 1); tick();
  endtask
  task automatic idle(input int n);
    hs = 0; ck = 0; repeat (n) tick();
  endtask
  // tail=0 leaves href high after the last pixel so the next frame's vsync rise coincides with href fall
  task automatic frame(input int nl, input int len, input bit gaps, input bit tail);
    vs = 1; hs = 0; ck = 0; tick();
    vs = 0; tick(); tick();
    for (int y = 0; y < nl; y++) begin
      for (int x = 0; x < len; x++) begin
        if (gaps) begin
          int g;
          g = int'($urandom_range(0, 2));
          for (int k = 0; k < g; k++) begin hs = 1; ck = 0; tick(); end
        end
        px(y, x);
      end
      if (tail || y != nl - 1) idle(2 + (gaps ? int'($urandom_range(0, 3)) : 0));
    end
  endtask

  initial begin
    rst = 1; vs = 0; hs = 0; ck = 0; pix = '0;
    repeat (3) tick();
    rst = 0; tick();

    // reset in the middle of a streaming line
    vs = 1; tick(); vs = 0; tick();
    px(0, 0); px(0, 1);
    rst = 1; hs = 1; ck = 1; pix = 8'h55; tick();
    check("rst_window", dut_win, 72'h0);
    check("rst_clken", o_ck, 1'b0);
    cap.delete();
    rst = 0;
    px(0, 2); px(0, 3); idle(3); px(1, 0); px(1, 1); idle(4);
    check("no_strobe_after_rst", cap.size(), 0);

    // plain 4x4 frame
    cap.delete();
    frame(4, 4, 0, 1); idle(4);
    check("count_4x4", cap.size(), 16);
    check("p00_win", cap[0],  72'h00_00_00_00_00_00_00_00_01);
    check("p22_win", cap[10], 72'h01_02_03_11_12_13_21_22_23);

    // random gaps inside and between lines
    cap.delete();
    frame(4, 4, 1, 1); idle(4);
    check("count_gaps", cap.size(), 16);
    check("p22_win_gaps", cap[10], 72'h01_02_03_11_12_13_21_22_23);

    // lines longer than IMG_WIDTH
    cap.delete();
    frame(3, 6, 0, 1); idle(4);
    check("count_wide", cap.size(), 18);
    check("p11_win_wide", cap[7],  72'h00_00_00_00_01_02_00_11_12);
    check("p14_win_wide", cap[10], 72'h00_00_00_00_00_00_13_14_15);
    check("p23_win_wide", cap[15], 72'h02_03_04_12_13_14_22_23_24);

    // back-to-back frames, vsync rise coincides with href fall
    cap.delete();
    frame(2, 4, 0, 0);
    frame(2, 4, 0, 1); idle(4);
    check("count_two_frames", cap.size(), 16);
    check("f2_p01_win", cap[9],  72'h00_00_00_00_00_00_00_01_02);
    check("f2_p12_win", cap[14], 72'h00_00_00_01_02_03_11_12_13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
